// File: rtl/xc_sha3_seq.sv
// Keccak lane-address sequencer: walks the 25 lanes (y outer, x inner), applies the selected
// index function and streams base + (index << shamt) over valid/ready. Option: XC_SHA3_SEQ_ROUNDS_EN.
module xc_sha3_seq #(
  parameter int unsigned AW = 32
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          start,
  input  logic [2:0]    cfg_op,
  input  logic [1:0]    cfg_shamt,
  input  logic [AW-1:0] cfg_base,
`ifdef XC_SHA3_SEQ_ROUNDS_EN
  input  logic [4:0]    cfg_rounds,
  output logic [4:0]    out_round,
`endif
  input  logic          abort,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [2:0]    out_x,
  output logic [2:0]    out_y,
  output logic          done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q;
  logic [2:0]    op_q;
  logic [1:0]    shamt_q;
  logic [AW-1:0] base_q;
  logic [2:0]    nx, ny;
  logic          last_lane;
`ifdef XC_SHA3_SEQ_ROUNDS_EN
  logic [4:0]    rounds_q;
`endif

  // Inputs never exceed 20, so a short compare/subtract chain is enough.
  function automatic logic [2:0] mod5(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (r >= 5'd20)      r = r - 5'd20;
    else if (r >= 5'd15) r = r - 5'd15;
    else if (r >= 5'd10) r = r - 5'd10;
    else if (r >= 5'd5)  r = r - 5'd5;
    return r[2:0];
  endfunction

  function automatic logic [AW-1:0] lane_addr(input logic [2:0]    op,
                                              input logic [1:0]    shamt,
                                              input logic [AW-1:0] base,
                                              input logic [2:0]    x,
                                              input logic [2:0]    y);
    logic [4:0] l, r;
    logic [6:0] idx;
    l = 5'(x);
    r = 5'(y);
    case (op)
      3'd1: l = 5'(x) + 5'd1;
      3'd2: l = 5'(x) + 5'd2;
      3'd3: l = 5'(x) + 5'd4;
      3'd4: begin
        l = 5'(y);
        r = 5'(x) * 5'd2 + 5'(y) * 5'd3;
      end
      default: ;
    endcase
    idx = 7'(mod5(l)) + 7'd5 * 7'(mod5(r));
    return base + (AW'(idx) << shamt);
  endfunction

  always_comb begin
    nx = out_x + 3'd1;
    ny = out_y;
    if (out_x == 3'd4) begin
      nx = 3'd0;
      ny = (out_y == 3'd4) ? 3'd0 : out_y + 3'd1;
    end
    last_lane = (out_x == 3'd4) && (out_y == 3'd4);
`ifdef XC_SHA3_SEQ_ROUNDS_EN
    last_lane = last_lane && (out_round == rounds_q - 5'd1);
`endif
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= StIdle;
      op_q      <= 3'd0;
      shamt_q   <= 2'd0;
      base_q    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_x     <= 3'd0;
      out_y     <= 3'd0;
      done      <= 1'b0;
`ifdef XC_SHA3_SEQ_ROUNDS_EN
      rounds_q  <= 5'd1;
      out_round <= 5'd0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRun;
            op_q      <= cfg_op;
            shamt_q   <= cfg_shamt;
            base_q    <= cfg_base;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_x     <= 3'd0;
            out_y     <= 3'd0;
            out_addr  <= lane_addr(cfg_op, cfg_shamt, cfg_base, 3'd0, 3'd0);
`ifdef XC_SHA3_SEQ_ROUNDS_EN
            rounds_q  <= (cfg_rounds == 5'd0) ? 5'd1 : cfg_rounds;
            out_round <= 5'd0;
`endif
          end
        end
        StRun: begin
          // abort wins over a simultaneous accept; the presented lane is dropped
          if (abort) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            if (last_lane) begin
              state_q   <= StIdle;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_x    <= nx;
              out_y    <= ny;
              out_addr <= lane_addr(op_q, shamt_q, base_q, nx, ny);
`ifdef XC_SHA3_SEQ_ROUNDS_EN
              if (out_x == 3'd4 && out_y == 3'd4) out_round <= out_round + 5'd1;
`endif
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_sha3_seq.sv
// Self-checking bench for xc_sha3_seq: table-driven sweeps with a lane scoreboard, plus
// hand-written abort, reset and (with XC_SHA3_SEQ_ROUNDS_EN) multi-round sequences.
module tb_xc_sha3_seq;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg_op = 3'd0;
  logic [1:0]  cfg_shamt = 2'd0;
  logic [31:0] cfg_base = 32'd0;
  logic        abort = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [2:0]  out_x;
  logic [2:0]  out_y;
  logic        done;
`ifdef XC_SHA3_SEQ_ROUNDS_EN
  logic [4:0]  cfg_rounds = 5'd0;
  logic [4:0]  out_round;
`endif

  xc_sha3_seq #(.AW(32)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .start     (start),
    .cfg_op    (cfg_op),
    .cfg_shamt (cfg_shamt),
    .cfg_base  (cfg_base),
`ifdef XC_SHA3_SEQ_ROUNDS_EN
    .cfg_rounds(cfg_rounds),
    .out_round (out_round),
`endif
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_x     (out_x),
    .out_y     (out_y),
    .done      (done)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [4:0]  rnd;
    bit          last;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  shamt;
    logic [31:0] base;
    bit          rnd_ready;
    logic [2:0]  px;
    logic [2:0]  py;
    logic [31:0] paddr;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          exp_done = 1'b0;
  bit          stall_prev = 1'b0;
  logic [37:0] held;
  bit          probe_en = 1'b0;
  logic [2:0]  px, py;
  logic [31:0] paddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_addr(int op, int shamt, logic [31:0] base, int x, int y);
    int l, r, idx;
    l = x;
    r = y;
    if (op == 1) l = x + 1;
    else if (op == 2) l = x + 2;
    else if (op == 3) l = x + 4;
    else if (op == 4) begin
      l = y;
      r = 2 * x + 3 * y;
    end
    idx = (l % 5) + 5 * (r % 5);
    return base + (32'(idx) << shamt);
  endfunction

  task automatic push_sweep(input vec_t v, input int nr);
    exp_t e;
    for (int r = 0; r < nr; r++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) begin
          e.addr = model_addr(int'(v.op), int'(v.shamt), v.base, x, y);
          e.x    = 3'(x);
          e.y    = 3'(y);
          e.rnd  = 5'(r);
          e.last = (r == nr - 1) && (x == 4) && (y == 4);
          q.push_back(e);
        end
  endtask

  // Lanes are compared on the negedge before the edge that accepts them.
  always @(negedge g_clk) begin
    if (mon_en) begin
      exp_t e;
      chk("done_pulse", 64'(done), 64'(exp_done));
      exp_done = 1'b0;
      if (stall_prev && !g_reset) chk("stall_hold", {26'd0, out_addr, out_x, out_y}, 64'(held));
      stall_prev = out_valid && !out_ready && !abort && !g_reset;
      held = {out_addr, out_x, out_y};
      if (out_valid && out_ready && !abort) begin
        if (q.size() == 0) begin
          chk("unexpected_lane", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("lane_addr", 64'(out_addr), 64'(e.addr));
          chk("lane_xy", 64'({out_x, out_y}), 64'({e.x, e.y}));
`ifdef XC_SHA3_SEQ_ROUNDS_EN
          chk("lane_round", 64'(out_round), 64'(e.rnd));
`endif
          if (probe_en && e.x == px && e.y == py) chk("probe_addr", 64'(out_addr), 64'(paddr));
          if (e.last) exp_done = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 on the done cycle.
  task automatic run_sweep(input vec_t v, input int rounds);
    int nr, n;
    nr = (rounds == 0) ? 1 : rounds;
    px = v.px;
    py = v.py;
    paddr = v.paddr;
    probe_en = 1'b1;
    cfg_op = v.op;
    cfg_shamt = v.shamt;
    cfg_base = v.base;
`ifdef XC_SHA3_SEQ_ROUNDS_EN
    cfg_rounds = 5'(rounds);
`endif
    out_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    push_sweep(v, nr);
    @(posedge g_clk); #1;
    chk("first_valid", 64'({busy, out_valid}), 64'b11);
    chk("first_xy", 64'({out_x, out_y}), 64'd0);
    n = 1;
    while (q.size() != 0 && n < 3000) begin
      if (v.rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      cfg_op = 3'($urandom);
      cfg_shamt = 2'($urandom);
      cfg_base = $urandom;
`ifdef XC_SHA3_SEQ_ROUNDS_EN
      cfg_rounds = 5'($urandom);
`endif
      @(posedge g_clk); #1;
      n++;
    end
    start = 1'b0;
    probe_en = 1'b0;
    if (q.size() != 0) begin
      chk("sweep_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end else begin
      chk("end_done", 64'({done, busy, out_valid}), 64'b100);
      if (!v.rnd_ready) chk("throughput_cycles", 64'(n), 64'(25 * nr + 1));
    end
  endtask

  initial begin
    vecs[0] = '{op: 3'd0, shamt: 2'd3, base: 32'h100, rnd_ready: 1'b0,
                px: 3'd4, py: 3'd4, paddr: 32'h1C0};
    vecs[1] = '{op: 3'd4, shamt: 2'd0, base: 32'h0, rnd_ready: 1'b0,
                px: 3'd1, py: 3'd0, paddr: 32'd10};
    vecs[2] = '{op: 3'd3, shamt: 2'd2, base: 32'h40, rnd_ready: 1'b1,
                px: 3'd3, py: 3'd2, paddr: 32'h70};
    vecs[3] = '{op: 3'd1, shamt: 2'd1, base: 32'hFFFF_FFF0, rnd_ready: 1'b1,
                px: 3'd4, py: 3'd4, paddr: 32'h18};
    vecs[4] = '{op: 3'd2, shamt: 2'd0, base: 32'h1000, rnd_ready: 1'b0,
                px: 3'd3, py: 3'd0, paddr: 32'h1000};
    vecs[5] = '{op: 3'd7, shamt: 2'd1, base: 32'h200, rnd_ready: 1'b1,
                px: 3'd2, py: 3'd1, paddr: 32'h20E};

    #1 g_reset = 1'b1;
    #1;
    chk("reset_ctrl", 64'({busy, out_valid, done}), 64'd0);
    chk("reset_addr", 64'(out_addr), 64'd0);
    chk("reset_xy", 64'({out_x, out_y}), 64'd0);
`ifdef XC_SHA3_SEQ_ROUNDS_EN
    chk("reset_round", 64'(out_round), 64'd0);
`endif
    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;
    mon_en = 1'b1;

    abort = 1'b1;
    @(posedge g_clk); #1;
    abort = 1'b0;
    chk("idle_abort", 64'({busy, out_valid, done}), 64'd0);

    // Back-to-back: each sweep starts on the previous done cycle.
    for (int i = 0; i < 6; i++) run_sweep(vecs[i], 1);

    // Abort after the 7th accepted lane.
    begin
      int n;
      vec_t v;
      v = vecs[0];
      cfg_op = 3'd0; cfg_shamt = 2'd0; cfg_base = 32'd0;
      v.op = 3'd0; v.shamt = 2'd0; v.base = 32'd0;
      out_ready = 1'b1;
      start = 1'b1;
      push_sweep(v, 1);
      @(posedge g_clk); #1;
      start = 1'b0;
      n = 0;
      while (q.size() > 18 && n < 100) begin
        @(posedge g_clk); #1;
        n++;
      end
      chk("abort_pos_xy", 64'({out_x, out_y}), 64'({3'd2, 3'd1}));
      abort = 1'b1;
      @(posedge g_clk); #1;
      abort = 1'b0;
      q.delete();
      chk("abort_ctrl", 64'({busy, out_valid, done}), 64'd0);
      repeat (3) @(posedge g_clk);
      #1;
      chk("abort_idle", 64'({busy, out_valid, done}), 64'd0);
    end
    run_sweep(vecs[1], 1);

    // Asynchronous reset in the middle of a sweep.
    cfg_op = vecs[2].op; cfg_shamt = vecs[2].shamt; cfg_base = vecs[2].base;
    out_ready = 1'b1;
    start = 1'b1;
    push_sweep(vecs[2], 1);
    @(posedge g_clk); #1;
    start = 1'b0;
    repeat (5) @(posedge g_clk);
    #1 g_reset = 1'b1;
    #1;
    chk("midreset_ctrl", 64'({busy, out_valid, done}), 64'd0);
    chk("midreset_out", 64'({out_addr, out_x, out_y}), 64'd0);
    q.delete();
    exp_done = 1'b0;
    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;
    run_sweep(vecs[0], 1);

`ifdef XC_SHA3_SEQ_ROUNDS_EN
    run_sweep(vecs[0], 3);
    run_sweep(vecs[1], 0);
`endif

    repeat (3) @(posedge g_clk);
    #1;
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
